// File: rtl/axi_st_downsizer.sv
// AXI Stream downsizer: accepts wide beats and emits one kept symbol per output
// beat in ascending index order, skipping null symbols and carrying sideband.
module axi_st_downsizer #(
  parameter int SYMBOL_W   = 8,
  parameter int SYMBOL_NUM = 8,
  parameter int TID_W      = 8,
  parameter int TDEST_W    = 8,
  parameter int TUSER_W    = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           s_tvalid,
  output logic                           s_tready,
  input  logic [SYMBOL_W*SYMBOL_NUM-1:0] s_tdata,
  input  logic [SYMBOL_NUM-1:0]          s_tstrb,
  input  logic [SYMBOL_NUM-1:0]          s_tkeep,
  input  logic                           s_tlast,
  input  logic [TID_W-1:0]               s_tid,
  input  logic [TDEST_W-1:0]             s_tdest,
  input  logic [TUSER_W-1:0]             s_tuser,
  output logic                           m_tvalid,
  input  logic                           m_tready,
  output logic [SYMBOL_W-1:0]            m_tdata,
  output logic                           m_tstrb,
  output logic                           m_tkeep,
  output logic                           m_tlast,
  output logic [TID_W-1:0]               m_tid,
  output logic [TDEST_W-1:0]             m_tdest,
  output logic [TUSER_W-1:0]             m_tuser,
  output logic                           err_null_last
);

  localparam int DATA_W = SYMBOL_W * SYMBOL_NUM;
  localparam int IDX_W  = (SYMBOL_NUM > 1) ? $clog2(SYMBOL_NUM) : 1;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                  state_r, state_nxt_s;
  logic [SYMBOL_NUM-1:0]   rem_r, rem_nxt_s;
  logic [DATA_W-1:0]       data_r;
  logic [SYMBOL_NUM-1:0]   strb_r;
  logic                    last_r;
  logic [TID_W-1:0]        tid_r;
  logic [TDEST_W-1:0]      tdest_r;
  logic [TUSER_W-1:0]      tuser_r;
  logic                    rst_done_r;
  logic                    err_r, err_nxt_s;

  logic [SYMBOL_NUM-1:0]   sel_oh_s;
  logic [IDX_W-1:0]        sel_idx_s;
  logic                    full_s;
  logic                    last_sym_s;
  logic                    s_hs_s, m_hs_s, load_s, null_s;

  // Lowest set bit of the remaining mask selects the symbol to emit.
  always_comb begin
    sel_idx_s = {IDX_W{1'b0}};
    for (int i = SYMBOL_NUM - 1; i >= 0; i--) begin
      if (rem_r[i]) begin
        sel_idx_s = IDX_W'(i);
      end else begin
        sel_idx_s = sel_idx_s;
      end
    end
  end

  assign sel_oh_s   = rem_r & (~rem_r + SYMBOL_NUM'(1'b1));
  assign full_s     = (state_r == SHIFT);
  assign last_sym_s = (rem_r != {SYMBOL_NUM{1'b0}}) && ((rem_r & ~sel_oh_s) == {SYMBOL_NUM{1'b0}});

  assign s_tready = rst_done_r & (~full_s | (last_sym_s & m_tready));
  assign s_hs_s   = s_tvalid & s_tready;
  assign m_hs_s   = full_s & m_tready;
  assign load_s   = s_hs_s & (s_tkeep != {SYMBOL_NUM{1'b0}});
  assign null_s   = s_hs_s & (s_tkeep == {SYMBOL_NUM{1'b0}});

  assign m_tvalid      = full_s;
  assign m_tdata       = data_r[sel_idx_s*SYMBOL_W +: SYMBOL_W];
  assign m_tstrb       = strb_r[sel_idx_s];
  assign m_tkeep       = 1'b1;
  assign m_tlast       = last_r & last_sym_s;
  assign m_tid         = tid_r;
  assign m_tdest       = tdest_r;
  assign m_tuser       = tuser_r;
  assign err_null_last = err_r;

  // Next state, next remaining mask and null-last error decision.
  always_comb begin
    state_nxt_s = state_r;
    rem_nxt_s   = rem_r;
    err_nxt_s   = null_s & s_tlast;
    case (state_r)
      EMPTY: begin
        if (load_s) begin
          state_nxt_s = SHIFT;
          rem_nxt_s   = s_tkeep;
        end else begin
          state_nxt_s = EMPTY;
          rem_nxt_s   = {SYMBOL_NUM{1'b0}};
        end
      end
      SHIFT: begin
        if (m_hs_s && last_sym_s) begin
          if (load_s) begin
            state_nxt_s = SHIFT;
            rem_nxt_s   = s_tkeep;
          end else begin
            state_nxt_s = EMPTY;
            rem_nxt_s   = {SYMBOL_NUM{1'b0}};
          end
        end else if (m_hs_s) begin
          state_nxt_s = SHIFT;
          rem_nxt_s   = rem_r & ~sel_oh_s;
        end else begin
          state_nxt_s = SHIFT;
          rem_nxt_s   = rem_r;
        end
      end
      default: begin
        state_nxt_s = EMPTY;
        rem_nxt_s   = {SYMBOL_NUM{1'b0}};
      end
    endcase
  end

  // State, mask, error pulse and reset-release tracking registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= EMPTY;
      rem_r      <= {SYMBOL_NUM{1'b0}};
      err_r      <= 1'b0;
      rst_done_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      rem_r      <= rem_nxt_s;
      err_r      <= err_nxt_s;
      rst_done_r <= 1'b1;
    end
  end

  // Holding register for the accepted beat payload and sideband.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r  <= {DATA_W{1'b0}};
      strb_r  <= {SYMBOL_NUM{1'b0}};
      last_r  <= 1'b0;
      tid_r   <= {TID_W{1'b0}};
      tdest_r <= {TDEST_W{1'b0}};
      tuser_r <= {TUSER_W{1'b0}};
    end else if (load_s) begin
      data_r  <= s_tdata;
      strb_r  <= s_tstrb;
      last_r  <= s_tlast;
      tid_r   <= s_tid;
      tdest_r <= s_tdest;
      tuser_r <= s_tuser;
    end
  end

endmodule

// File: tb/tb_axi_st_downsizer.sv
// Randomized and directed bench for axi_st_downsizer with a queue-based
// reference model of the emitted symbol stream.
module tb_axi_st_downsizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_tvalid;
  logic        s_tready;
  logic [63:0] s_tdata;
  logic [7:0]  s_tstrb, s_tkeep;
  logic        s_tlast;
  logic [7:0]  s_tid, s_tdest, s_tuser;
  logic        m_tvalid;
  logic        m_tready;
  logic [7:0]  m_tdata;
  logic        m_tstrb, m_tkeep, m_tlast;
  logic [7:0]  m_tid, m_tdest, m_tuser;
  logic        err_null_last;

  int checks = 0;
  int errors = 0;
  bit rand_rdy = 1'b0;

  typedef struct packed {
    logic [7:0] d;
    logic       s;
    logic       l;
    logic [7:0] id;
    logic [7:0] de;
    logic [7:0] us;
  } sym_t;

  sym_t q[$];

  axi_st_downsizer dut (
    .clk(clk), .rst_n(rst_n),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .s_tstrb(s_tstrb), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
    .s_tid(s_tid), .s_tdest(s_tdest), .s_tuser(s_tuser),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .m_tstrb(m_tstrb), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
    .m_tid(m_tid), .m_tdest(m_tdest), .m_tuser(m_tuser),
    .err_null_last(err_null_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream ready: always high unless the random phase is active.
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Reference model and per-cycle compare, sampled on the falling edge.
  int   rel_cnt = 0;
  bit   err_pend = 1'b0;
  bit   prev_stall = 1'b0;
  sym_t prev_out;
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
      chk("rst_s_tready", 64'(s_tready), 64'd0);
      chk("rst_m_tdata", 64'(m_tdata), 64'd0);
      chk("rst_m_tlast", 64'(m_tlast), 64'd0);
      chk("rst_m_tstrb", 64'(m_tstrb), 64'd0);
      chk("rst_side", 64'({m_tid, m_tdest, m_tuser}), 64'd0);
      chk("rst_err", 64'(err_null_last), 64'd0);
      q.delete();
      err_pend   = 1'b0;
      prev_stall = 1'b0;
      rel_cnt    = 0;
    end else begin
      chk("s_tready", 64'(s_tready),
          64'((rel_cnt >= 1) && ((q.size() == 0) || ((q.size() == 1) && m_tready))));
      chk("m_tvalid", 64'(m_tvalid), 64'(q.size() != 0));
      chk("err_null_last", 64'(err_null_last), 64'(err_pend));
      if (m_tvalid && (q.size() != 0)) begin
        chk("m_out", 64'({m_tdata, m_tstrb, m_tlast, m_tid, m_tdest, m_tuser}), 64'(q[0]));
        chk("m_tkeep", 64'(m_tkeep), 64'd1);
      end
      if (prev_stall) begin
        chk("stall_stable", 64'({m_tvalid, m_tdata, m_tlast, m_tstrb}),
            64'({1'b1, prev_out.d, prev_out.l, prev_out.s}));
      end
      prev_stall = m_tvalid & ~m_tready;
      prev_out.d = m_tdata;
      prev_out.l = m_tlast;
      prev_out.s = m_tstrb;
      if (m_tvalid && m_tready && (q.size() != 0)) void'(q.pop_front());
      err_pend = 1'b0;
      if (s_tvalid && s_tready) begin
        if (s_tkeep == 8'h00) begin
          err_pend = s_tlast;
        end else begin
          int hi = 0;
          for (int i = 0; i < 8; i++) if (s_tkeep[i]) hi = i;
          for (int i = 0; i < 8; i++) begin
            if (s_tkeep[i]) begin
              sym_t e;
              e.d  = s_tdata[i*8 +: 8];
              e.s  = s_tstrb[i];
              e.l  = s_tlast && (i == hi);
              e.id = s_tid;
              e.de = s_tdest;
              e.us = s_tuser;
              q.push_back(e);
            end
          end
        end
      end
      if (rel_cnt < 2) rel_cnt++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic [7:0] st,
                           input logic l, input logic [7:0] id, input logic [7:0] de,
                           input logic [7:0] us);
    bit acc = 1'b0;
    bit rdy;
    int n = 0;
    s_tdata = d; s_tkeep = k; s_tstrb = st; s_tlast = l;
    s_tid = id; s_tdest = de; s_tuser = us;
    s_tvalid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      rdy = s_tready;
      @(posedge clk);
      #1;
      acc = rdy;
      n++;
    end
    chk("send_accept", 64'(acc), 64'd1);
    s_tvalid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_tvalid && n < 50);
    chk("wait_valid", 64'(m_tvalid), 64'd1);
  endtask

  initial begin
    int n, cnt, pulses, valids;
    rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = 64'd0; s_tkeep = 8'd0; s_tstrb = 8'd0;
    s_tlast = 1'b0; s_tid = 8'd0; s_tdest = 8'd0; s_tuser = 8'd0;
    idle(3);
    rst_n = 1'b1;
    idle(3);

    // Full beat: symbols 0x00..0x07, tlast only on the final one.
    fork
      send_beat(64'h0706050403020100, 8'hFF, 8'hFF, 1'b1, 8'h01, 8'h02, 8'h03);
      begin
        wait_valid(n);
        chk("t1_latency", 64'(n), 64'd2);
        for (int i = 0; i < 8; i++) begin
          chk("t1_data", 64'(m_tdata), 64'(i));
          chk("t1_last", 64'(m_tlast), 64'(i == 7));
          chk("t1_s_tready", 64'(s_tready), 64'(i == 7));
          if (i < 7) @(negedge clk);
        end
      end
    join
    idle(2);

    // Sparse keep 0x81: 0xBB then 0xAA with no gap.
    fork
      send_beat(64'hAA000000000000BB, 8'h81, 8'h01, 1'b1, 8'h05, 8'h06, 8'h07);
      begin
        wait_valid(n);
        chk("t2_first", 64'({m_tdata, m_tstrb, m_tlast}), 64'({8'hBB, 1'b1, 1'b0}));
        @(negedge clk);
        chk("t2_second", 64'({m_tvalid, m_tdata, m_tstrb, m_tlast}),
            64'({1'b1, 8'hAA, 1'b0, 1'b1}));
      end
    join
    idle(2);

    // Three back-to-back full beats: 24 valid cycles, sideband switches per beat.
    fork
      for (int b = 0; b < 3; b++)
        send_beat({$urandom, $urandom}, 8'hFF, 8'hFF, 1'b1, 8'(8'h10 + b), 8'(8'h20 + b), 8'(8'h30 + b));
      begin
        wait_valid(n);
        cnt = 0;
        while (m_tvalid && cnt < 40) begin
          chk("t3_tid", 64'(m_tid), 64'(8'h10 + cnt / 8));
          cnt++;
          @(negedge clk);
        end
        chk("t3_run", 64'(cnt), 64'd24);
      end
    join
    idle(2);

    // Null beats: with tlast one error pulse, without tlast silent.
    send_beat(64'h1122334455667788, 8'h00, 8'hFF, 1'b1, 8'h00, 8'h00, 8'h00);
    pulses = 0; valids = 0;
    repeat (4) begin
      @(negedge clk);
      pulses += int'(err_null_last);
      valids += int'(m_tvalid);
    end
    chk("null_last_pulses", 64'(pulses), 64'd1);
    chk("null_last_valid", 64'(valids), 64'd0);
    idle(1);
    send_beat(64'h1122334455667788, 8'h00, 8'hFF, 1'b0, 8'h00, 8'h00, 8'h00);
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      pulses += int'(err_null_last);
    end
    chk("null_nolast_pulses", 64'(pulses), 64'd0);
    idle(1);

    // Random beats with random backpressure.
    rand_rdy = 1'b1;
    for (int b = 0; b < 100; b++) begin
      logic [7:0] k;
      k = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
      send_beat({$urandom, $urandom}, k, 8'($urandom), 1'($urandom_range(0, 1)),
                8'($urandom), 8'($urandom), 8'($urandom));
      idle(int'($urandom_range(0, 2)));
    end
    rand_rdy = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_tvalid && n < 200);
    chk("drain", 64'(m_tvalid), 64'd0);
    idle(2);

    // Reset after three of eight symbols; next beat restarts cleanly.
    fork
      send_beat(64'h0F0E0D0C0B0A0908, 8'hFF, 8'hFF, 1'b1, 8'h41, 8'h42, 8'h43);
      begin
        wait_valid(n);
        @(negedge clk);
        @(negedge clk);
      end
    join_any
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 64'(m_tvalid), 64'd0);
    idle(2);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_s_tready0", 64'(s_tready), 64'd0);
    @(negedge clk);
    chk("rel_s_tready1", 64'(s_tready), 64'd1);
    chk("rel_no_valid", 64'(m_tvalid), 64'd0);
    @(posedge clk);
    #1;
    fork
      send_beat(64'h1716151413121110, 8'hFF, 8'hFF, 1'b1, 8'h51, 8'h52, 8'h53);
      begin
        wait_valid(n);
        chk("post_rst_first", 64'(m_tdata), 64'h10);
      end
    join
    idle(10);
    chk("final_queue_empty", 64'(q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
